// File: rtl/voter_session.sv
// voter_session
//   Runs one ballot session over N_VOTERS voters. Each voter may cast a
//   single approve/reject vote while the session is OPEN. The session closes
//   when every voter has voted or the timer expires. A one-cycle TALLY state
//   then produces a registered one-hot result with a done pulse. An abort
//   input cancels the session without producing a result.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   start      : open a session (IDLE only, ignored together with abort)
//   abort      : cancel the current session (OPEN/TALLY)
//   vote_valid : per-voter vote strobe
//   vote_val   : per-voter vote value, 1 = approve, 0 = reject
//   busy       : high in OPEN and TALLY
//   done       : one-cycle pulse, result valid from this cycle
//   result     : one-hot {approve, tie, reject}; 000 = no result
//   quorum_ok  : ballots cast >= QUORUM for the last completed session
//   yes_cnt    : accepted approve votes
//   no_cnt     : accepted reject votes
//   voted      : per-voter "has an accepted vote" flags
module voter_session #(
  parameter int N_VOTERS = 4,
  parameter int QUORUM   = 3,
  parameter int TIMEOUT  = 16,
  localparam int CNT_W   = $clog2(N_VOTERS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [N_VOTERS-1:0] vote_valid,
  input  logic [N_VOTERS-1:0] vote_val,
  output logic                busy,
  output logic                done,
  output logic [2:0]          result,
  output logic                quorum_ok,
  output logic [CNT_W-1:0]    yes_cnt,
  output logic [CNT_W-1:0]    no_cnt,
  output logic [N_VOTERS-1:0] voted
);

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_W:0]   QUORUM_C = (CNT_W + 1)'(QUORUM);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OPEN  = 2'd1,
    ST_TALLY = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [N_VOTERS-1:0] voted_q, voted_d;
  logic [CNT_W-1:0]    yes_q, yes_d;
  logic [CNT_W-1:0]    no_q, no_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [2:0]          result_q, result_d;
  logic                quorum_q, quorum_d;
  logic                done_q, done_d;

  // Votes accepted this edge: only while OPEN, not aborting, first vote only.
  logic [N_VOTERS-1:0] accept;
  logic [CNT_W-1:0]    yes_add, no_add;
  logic [CNT_W:0]      cast;

  always_comb begin
    accept  = '0;
    yes_add = '0;
    no_add  = '0;
    if (state_q == ST_OPEN && !abort) begin
      accept = vote_valid & ~voted_q;
    end
    for (int i = 0; i < N_VOTERS; i++) begin
      yes_add = yes_add + CNT_W'(accept[i] & vote_val[i]);
      no_add  = no_add + CNT_W'(accept[i] & ~vote_val[i]);
    end
  end

  assign cast = {1'b0, yes_q} + {1'b0, no_q};

  always_comb begin
    state_d  = state_q;
    voted_d  = voted_q;
    yes_d    = yes_q;
    no_d     = no_q;
    timer_d  = timer_q;
    result_d = result_q;
    quorum_d = quorum_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // start together with abort is dropped without touching any state
        if (start && !abort) begin
          state_d  = ST_OPEN;
          voted_d  = '0;
          yes_d    = '0;
          no_d     = '0;
          timer_d  = '0;
          result_d = 3'b000;
          quorum_d = 1'b0;
        end
      end
      ST_OPEN: begin
        if (abort) begin
          // counters and voted flags are left as they were
          state_d  = ST_IDLE;
          result_d = 3'b000;
          quorum_d = 1'b0;
        end else begin
          voted_d = voted_q | accept;
          yes_d   = yes_q + yes_add;
          no_d    = no_q + no_add;
          timer_d = timer_q + TMR_W'(1);
          if ((&voted_d) || (timer_q == TMR_LAST)) begin
            state_d = ST_TALLY;
          end
        end
      end
      ST_TALLY: begin
        state_d = ST_IDLE;
        if (abort) begin
          result_d = 3'b000;
          quorum_d = 1'b0;
        end else begin
          done_d = 1'b1;
          if (cast < QUORUM_C) begin
            result_d = 3'b001;
            quorum_d = 1'b0;
          end else begin
            quorum_d = 1'b1;
            if (yes_q > no_q)       result_d = 3'b100;
            else if (yes_q == no_q) result_d = 3'b010;
            else                    result_d = 3'b001;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      voted_q  <= '0;
      yes_q    <= '0;
      no_q     <= '0;
      timer_q  <= '0;
      result_q <= 3'b000;
      quorum_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      voted_q  <= voted_d;
      yes_q    <= yes_d;
      no_q     <= no_d;
      timer_q  <= timer_d;
      result_q <= result_d;
      quorum_q <= quorum_d;
      done_q   <= done_d;
    end
  end

  assign busy      = (state_q == ST_OPEN) || (state_q == ST_TALLY);
  assign done      = done_q;
  assign result    = result_q;
  assign quorum_ok = quorum_q;
  assign yes_cnt   = yes_q;
  assign no_cnt    = no_q;
  assign voted     = voted_q;

endmodule

// File: tb/tb_voter_session.sv
// tb_voter_session
//   Directed bench for voter_session (N_VOTERS=4, QUORUM=3, TIMEOUT=16).
//   Inputs change 1 time unit after a rising edge; outputs are sampled at
//   the same point, well clear of the next edge.
module tb_voter_session;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [3:0] vote_valid;
  logic [3:0] vote_val;
  logic       busy;
  logic       done;
  logic [2:0] result;
  logic       quorum_ok;
  logic [2:0] yes_cnt;
  logic [2:0] no_cnt;
  logic [3:0] voted;

  int checks;
  int errors;
  int n;
  logic seen_done;

  voter_session #(
    .N_VOTERS(4),
    .QUORUM  (3),
    .TIMEOUT (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .vote_valid(vote_valid),
    .vote_val  (vote_val),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .quorum_ok (quorum_ok),
    .yes_cnt   (yes_cnt),
    .no_cnt    (no_cnt),
    .voted     (voted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " busy"},   32'(busy), 0);
    check({tag, " done"},   32'(done), 0);
    check({tag, " result"}, 32'(result), 0);
    check({tag, " quorum"}, 32'(quorum_ok), 0);
    check({tag, " yes"},    32'(yes_cnt), 0);
    check({tag, " no"},     32'(no_cnt), 0);
    check({tag, " voted"},  32'(voted), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    vote_valid = 4'b0000;
    vote_val   = 4'b0000;
    tick();
    tick();
    check_idle_zero("por");
    rst_n = 1'b1;
    tick();

    // Majority 3-1, closes on the edge of the last vote
    start = 1'b1;
    tick();
    start = 1'b0;
    check("maj busy", 32'(busy), 1);
    vote_valid = 4'b0111; vote_val = 4'b0111;
    tick();
    vote_valid = 4'b0000;
    check("maj yes3", 32'(yes_cnt), 3);
    check("maj voted0111", 32'(voted), 4'b0111);
    tick();
    vote_valid = 4'b1000; vote_val = 4'b0000;
    tick();
    vote_valid = 4'b0000;
    check("maj tally busy", 32'(busy), 1);
    check("maj tally done", 32'(done), 0);
    check("maj no1", 32'(no_cnt), 1);
    check("maj voted1111", 32'(voted), 4'b1111);
    tick();
    check("maj done", 32'(done), 1);
    check("maj result", 32'(result), 3'b100);
    check("maj quorum", 32'(quorum_ok), 1);
    check("maj yes", 32'(yes_cnt), 3);
    check("maj no", 32'(no_cnt), 1);
    check("maj busy0", 32'(busy), 0);

    // Tie; start during the done cycle, with votes presented that must be ignored
    start = 1'b1; vote_valid = 4'b1111; vote_val = 4'b1111;
    tick();
    start = 1'b0; vote_valid = 4'b0000;
    check("tie open busy", 32'(busy), 1);
    check("tie open voted", 32'(voted), 0);
    check("tie open yes", 32'(yes_cnt), 0);
    check("tie open result", 32'(result), 0);
    check("tie open quorum", 32'(quorum_ok), 0);
    check("tie open done", 32'(done), 0);
    vote_valid = 4'b1111; vote_val = 4'b0101;
    tick();
    vote_valid = 4'b0000;
    check("tie +1 done", 32'(done), 0);
    tick();
    check("tie +2 done", 32'(done), 1);
    check("tie result", 32'(result), 3'b010);
    check("tie yes", 32'(yes_cnt), 2);
    check("tie no", 32'(no_cnt), 2);
    check("tie quorum", 32'(quorum_ok), 1);

    // Timeout with no quorum: 16 OPEN cycles, TALLY, then done
    start = 1'b1;
    tick();
    start = 1'b0;
    vote_valid = 4'b0011; vote_val = 4'b0011;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      vote_valid = 4'b0000;
      n++;
      if (done) break;
    end
    check("tmo cycles", 32'(n), 17);
    check("tmo result", 32'(result), 3'b001);
    check("tmo quorum", 32'(quorum_ok), 0);
    check("tmo yes", 32'(yes_cnt), 2);
    check("tmo no", 32'(no_cnt), 0);
    check("tmo voted", 32'(voted), 4'b0011);

    // Repeat vote from voter 0 is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    vote_valid = 4'b0001; vote_val = 4'b0001;
    tick();
    vote_valid = 4'b0001; vote_val = 4'b0000;
    tick();
    vote_valid = 4'b0000;
    check("rep yes", 32'(yes_cnt), 1);
    check("rep no", 32'(no_cnt), 0);
    vote_valid = 4'b1110; vote_val = 4'b0000;
    tick();
    vote_valid = 4'b0000;
    tick();
    check("rep done", 32'(done), 1);
    check("rep result", 32'(result), 3'b001);
    check("rep quorum", 32'(quorum_ok), 1);
    check("rep yes final", 32'(yes_cnt), 1);
    check("rep no final", 32'(no_cnt), 3);
    tick();

    // start together with abort in IDLE: nothing changes
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("sa busy", 32'(busy), 0);
    check("sa result held", 32'(result), 3'b001);
    check("sa yes held", 32'(yes_cnt), 1);
    check("sa no held", 32'(no_cnt), 3);
    tick();
    check("sa still idle", 32'(busy), 0);

    // Abort in the 5th OPEN cycle with votes presented
    start = 1'b1;
    tick();
    start = 1'b0;
    vote_valid = 4'b0001; vote_val = 4'b0001;
    tick();
    vote_valid = 4'b0000;
    tick();
    tick();
    tick();
    abort = 1'b1; vote_valid = 4'b1110; vote_val = 4'b1110;
    tick();
    abort = 1'b0; vote_valid = 4'b0000;
    check("abt busy", 32'(busy), 0);
    check("abt result", 32'(result), 0);
    check("abt quorum", 32'(quorum_ok), 0);
    check("abt yes", 32'(yes_cnt), 1);
    check("abt no", 32'(no_cnt), 0);
    check("abt voted", 32'(voted), 4'b0001);
    seen_done = done;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen_done = seen_done | done;
    end
    check("abt no done", 32'(seen_done), 0);

    // Reset mid-OPEN after two accepted votes
    start = 1'b1;
    tick();
    start = 1'b0;
    vote_valid = 4'b0011; vote_val = 4'b0001;
    tick();
    vote_valid = 4'b0000;
    check("rst pre yes", 32'(yes_cnt), 1);
    check("rst pre no", 32'(no_cnt), 1);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check_idle_zero("rst");
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rst2 busy", 32'(busy), 1);
    vote_valid = 4'b1111; vote_val = 4'b1111;
    tick();
    vote_valid = 4'b0000;
    tick();
    check("rst2 done", 32'(done), 1);
    check("rst2 result", 32'(result), 3'b100);
    check("rst2 yes", 32'(yes_cnt), 4);
    check("rst2 quorum", 32'(quorum_ok), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
